// File: rtl/simple_system_pkg.sv
// Shared definitions for the simple-system data memory.
// Holds the bus widths and the response record carried through the
// response pipeline. Contains no logic and has no ports.
package simple_system_pkg;

    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned BeWidth   = 4;

    // One response slot. When valid is 0 the whole slot is zero. That
    // keeps rdata/err low on the bus whenever rvalid is low.
    typedef struct packed {
        logic                 valid;
        logic [DataWidth-1:0] rdata;
        logic                 err;
    } dmem_resp_t;

endpackage

// File: rtl/simple_system_dmem_if.sv
// LSU request/response bus between the core and the data memory.
// Signals:
//   req, we, be, addr, wdata : request from the master
//   gnt                      : request accepted this cycle (from the slave)
//   rvalid, rdata, err       : in-order response (from the slave)
// Modports: master (core side), slave (memory side).
interface simple_system_dmem_if
    import simple_system_pkg::*;
    ();

    logic                 req;
    logic                 gnt;
    logic                 we;
    logic [BeWidth-1:0]   be;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] wdata;
    logic                 rvalid;
    logic [DataWidth-1:0] rdata;
    logic                 err;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata, err
    );

endinterface

// File: rtl/simple_system_resp_pipe.sv
// Fixed-latency response pipeline for the data memory.
// The slot presented on "entry" appears on "head" exactly Depth clocks
// later. An asynchronous active-low clear empties every slot.
// Ports:
//   clk   in   clock
//   rst_n in   asynchronous active-low clear
//   entry in   response slot captured this clock (all-zero when idle)
//   head  out  oldest slot, Depth clocks after capture
module simple_system_resp_pipe
    import simple_system_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  dmem_resp_t entry,
    output dmem_resp_t head
);

    dmem_resp_t stages [Depth];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= entry;
            for (int unsigned i = 1; i < Depth; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign head = stages[Depth-1];

endmodule

// File: rtl/simple_system_dmem.sv
// Data-side memory responder for the simple system.
// This is a word-organised RAM on the LSU req/gnt/rvalid bus. It has a
// fixed response latency and a limit on outstanding requests. It can
// also force a periodic stall of the grant.
// Ports:
//   clk_i  in     clock
//   rst_ni in     asynchronous active-low reset (the RAM array is not reset)
//   bus    slave  request/response bus (see simple_system_dmem_if)
module simple_system_dmem
    import simple_system_pkg::*;
#(
    parameter int unsigned    MemSizeBytes   = 65536,
    parameter logic [31:0]    BaseAddr       = 32'h0010_0000,
    parameter int unsigned    RespLatency    = 1,
    parameter int unsigned    MaxOutstanding = 2,
    parameter int unsigned    GntStallEvery  = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    simple_system_dmem_if.slave  bus
);

    localparam int unsigned AddrBits = $clog2(MemSizeBytes);
    localparam int unsigned Words    = MemSizeBytes / 4;
    localparam int unsigned IdxW     = (AddrBits > 2) ? AddrBits - 2 : 1;
    localparam int unsigned CntW     = $clog2(MaxOutstanding + 1);
    localparam int unsigned StallW   = (GntStallEvery > 0) ? $clog2(GntStallEvery + 1) : 1;

    if (MemSizeBytes < 4 || (MemSizeBytes & (MemSizeBytes - 1)) != 0) begin : g_bad_size
        $error("MemSizeBytes must be a power of two >= 4");
    end
    if ((BaseAddr & 32'(MemSizeBytes - 1)) != 32'h0) begin : g_bad_base
        $error("BaseAddr must be aligned to MemSizeBytes");
    end
    if (RespLatency < 1 || RespLatency > 4) begin : g_bad_latency
        $error("RespLatency must be in 1..4");
    end
    if (MaxOutstanding < 1 || MaxOutstanding > RespLatency + 1) begin : g_bad_outstanding
        $error("MaxOutstanding must be in 1..RespLatency+1");
    end

    logic [DataWidth-1:0] mem [Words];

    logic [AddrWidth-1:0] off;
    logic                 in_range;
    logic [IdxW-1:0]      idx;
    logic [CntW-1:0]      count;
    logic [StallW-1:0]    acc_cnt;
    logic                 stall_now;
    logic                 gnt;
    logic                 accept;
    dmem_resp_t           entry;
    dmem_resp_t           head;

    // Decode. The subtraction wraps, so addresses below the base land far
    // above MemSizeBytes and are reported as out of range. For a
    // single-word RAM the slice below is bit 2, which is always 0 when the
    // address is in range.
    assign off      = bus.addr - BaseAddr;
    assign in_range = off < 32'(MemSizeBytes);
    assign idx      = off[IdxW+1:2];

    // The stall fires only in a requesting cycle. A pending stall survives
    // idle cycles until the next request arrives.
    assign stall_now = (GntStallEvery != 0) && bus.req && (acc_cnt == StallW'(GntStallEvery));
    assign gnt       = bus.req && (count < CntW'(MaxOutstanding)) && !stall_now;
    assign accept    = gnt;

    always_comb begin
        entry = '0;
        if (accept) begin
            entry.valid = 1'b1;
            if (!in_range) begin
                entry.err = 1'b1;
            end else if (!bus.we) begin
                entry.rdata = mem[idx];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept && bus.we && in_range) begin
            for (int unsigned n = 0; n < BeWidth; n++) begin
                if (bus.be[n]) begin
                    mem[idx][8*n +: 8] <= bus.wdata[8*n +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count   <= '0;
            acc_cnt <= '0;
        end else begin
            case ({accept, head.valid})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
            if (stall_now) begin
                acc_cnt <= '0;
            end else if (accept && GntStallEvery != 0) begin
                acc_cnt <= acc_cnt + StallW'(1);
            end
        end
    end

    simple_system_resp_pipe #(
        .Depth(RespLatency)
    ) u_resp_pipe (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .entry (entry),
        .head  (head)
    );

    assign bus.gnt    = gnt;
    assign bus.rvalid = head.valid;
    assign bus.rdata  = head.rdata;
    assign bus.err    = head.err;

    a_no_orphan_rvalid: assert property (
        @(posedge clk_i) disable iff (!rst_ni) head.valid |-> (count != '0)
    );

endmodule

// File: tb/tb_simple_system_dmem.sv
// Directed testbench for simple_system_dmem. There are three instances:
//   a: defaults (latency 1, 2 outstanding, no stall)
//   b: latency 3, 2 outstanding
//   c: latency 1, grant stall after every 2 accepts
// Inputs are driven on the falling edge. Outputs are sampled 1ns later.
module tb_simple_system_dmem;

    logic clk = 1'b0;
    logic rst_ni = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    simple_system_dmem_if ifa ();
    simple_system_dmem_if ifb ();
    simple_system_dmem_if ifc ();

    simple_system_dmem #(
        .MemSizeBytes(65536), .BaseAddr(32'h0010_0000), .RespLatency(1),
        .MaxOutstanding(2), .GntStallEvery(0)
    ) dut_a (.clk_i(clk), .rst_ni(rst_ni), .bus(ifa));

    simple_system_dmem #(
        .MemSizeBytes(65536), .BaseAddr(32'h0010_0000), .RespLatency(3),
        .MaxOutstanding(2), .GntStallEvery(0)
    ) dut_b (.clk_i(clk), .rst_ni(rst_ni), .bus(ifb));

    simple_system_dmem #(
        .MemSizeBytes(65536), .BaseAddr(32'h0010_0000), .RespLatency(1),
        .MaxOutstanding(2), .GntStallEvery(2)
    ) dut_c (.clk_i(clk), .rst_ni(rst_ni), .bus(ifc));

    task automatic idle_all();
        ifa.req = 0; ifa.we = 0; ifa.be = '0; ifa.addr = '0; ifa.wdata = '0;
        ifb.req = 0; ifb.we = 0; ifb.be = '0; ifb.addr = '0; ifb.wdata = '0;
        ifc.req = 0; ifc.we = 0; ifc.be = '0; ifc.addr = '0; ifc.wdata = '0;
    endtask

    task automatic test_reset();
        idle_all();
        #2 rst_ni = 1'b0;
        #1;
        vectors++; if (ifa.rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_a_rvalid got %b want 0", ifa.rvalid); end
        vectors++; if (ifa.rdata !== 32'h0) begin miscompares++; $display("FAIL reset_a_rdata got %h want 0", ifa.rdata); end
        vectors++; if (ifa.err !== 1'b0) begin miscompares++; $display("FAIL reset_a_err got %b want 0", ifa.err); end
        vectors++; if (ifb.rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_b_rvalid got %b want 0", ifb.rvalid); end
        vectors++; if (ifc.rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_c_rvalid got %b want 0", ifc.rvalid); end
        vectors++; if (ifa.gnt !== 1'b0) begin miscompares++; $display("FAIL reset_a_gnt_noreq got %b want 0", ifa.gnt); end
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic test_word_rw();
        @(negedge clk);
        ifa.req = 1; ifa.we = 1; ifa.be = 4'hF; ifa.addr = 32'h0010_0010; ifa.wdata = 32'hDEAD_BEEF;
        #1;
        vectors++; if (ifa.gnt !== 1'b1) begin miscompares++; $display("FAIL word_wr_gnt got %b want 1", ifa.gnt); end
        vectors++; if (ifa.rvalid !== 1'b0) begin miscompares++; $display("FAIL word_pre_rvalid got %b want 0", ifa.rvalid); end
        @(negedge clk);
        ifa.we = 0; ifa.wdata = '0;
        #1;
        vectors++; if (ifa.gnt !== 1'b1) begin miscompares++; $display("FAIL word_rd_gnt got %b want 1", ifa.gnt); end
        vectors++; if (ifa.rvalid !== 1'b1) begin miscompares++; $display("FAIL word_wr_rvalid got %b want 1", ifa.rvalid); end
        vectors++; if (ifa.rdata !== 32'h0) begin miscompares++; $display("FAIL word_wr_rdata got %h want 0", ifa.rdata); end
        vectors++; if (ifa.err !== 1'b0) begin miscompares++; $display("FAIL word_wr_err got %b want 0", ifa.err); end
        @(negedge clk);
        ifa.req = 0;
        #1;
        vectors++; if (ifa.rvalid !== 1'b1) begin miscompares++; $display("FAIL word_rd_rvalid got %b want 1", ifa.rvalid); end
        vectors++; if (ifa.rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL word_rd_rdata got %h want deadbeef", ifa.rdata); end
        vectors++; if (ifa.err !== 1'b0) begin miscompares++; $display("FAIL word_rd_err got %b want 0", ifa.err); end
        @(negedge clk);
        #1;
        vectors++; if (ifa.rvalid !== 1'b0) begin miscompares++; $display("FAIL word_idle_rvalid got %b want 0", ifa.rvalid); end
        vectors++; if (ifa.rdata !== 32'h0) begin miscompares++; $display("FAIL word_idle_rdata got %h want 0", ifa.rdata); end
    endtask

    // Back-to-back ops on instance a. Each response is due one cycle after its accept.
    task automatic test_byte_lanes();
        logic        op_we [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [3:0]  op_be [4] = '{4'hF, 4'b0001, 4'h0, 4'hF};
        logic [31:0] op_wd [4] = '{32'h1122_3344, 32'h0000_00AA, 32'hFFFF_FFFF, 32'h0};
        logic [31:0] ex_rd [4] = '{32'h0, 32'h0, 32'h0, 32'h1122_33AA};
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i < 4) begin
                ifa.req = 1; ifa.we = op_we[i]; ifa.be = op_be[i];
                ifa.addr = 32'h0010_0000; ifa.wdata = op_wd[i];
            end else begin
                ifa.req = 0;
            end
            #1;
            if (i < 4) begin
                vectors++; if (ifa.gnt !== 1'b1) begin miscompares++; $display("FAIL byte_gnt[%0d] got %b want 1", i, ifa.gnt); end
            end
            if (i > 0) begin
                vectors++; if (ifa.rvalid !== 1'b1) begin miscompares++; $display("FAIL byte_rvalid[%0d] got %b want 1", i-1, ifa.rvalid); end
                vectors++; if (ifa.rdata !== ex_rd[i-1]) begin miscompares++; $display("FAIL byte_rdata[%0d] got %h want %h", i-1, ifa.rdata, ex_rd[i-1]); end
                vectors++; if (ifa.err !== 1'b0) begin miscompares++; $display("FAIL byte_err[%0d] got %b want 0", i-1, ifa.err); end
            end
        end
    endtask

    task automatic test_out_of_range();
        logic        op_we [7] = '{0, 0, 1, 0, 1, 0, 0};
        logic [31:0] op_ad [7] = '{32'h0000_0000, 32'h0011_0000, 32'h0011_0000, 32'h000F_FFFC,
                                   32'h0010_FFFC, 32'h0010_FFFC, 32'h0010_0000};
        logic [31:0] op_wd [7] = '{32'h0, 32'h0, 32'h5555_5555, 32'h0, 32'hCAFE_F00D, 32'h0, 32'h0};
        logic        ex_er [7] = '{1, 1, 1, 1, 0, 0, 0};
        logic [31:0] ex_rd [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hCAFE_F00D, 32'h1122_33AA};
        for (int i = 0; i <= 7; i++) begin
            @(negedge clk);
            if (i < 7) begin
                ifa.req = 1; ifa.we = op_we[i]; ifa.be = 4'hF;
                ifa.addr = op_ad[i]; ifa.wdata = op_wd[i];
            end else begin
                ifa.req = 0;
            end
            #1;
            if (i > 0) begin
                vectors++; if (ifa.rvalid !== 1'b1) begin miscompares++; $display("FAIL oor_rvalid[%0d] got %b want 1", i-1, ifa.rvalid); end
                vectors++; if (ifa.err !== ex_er[i-1]) begin miscompares++; $display("FAIL oor_err[%0d] got %b want %b", i-1, ifa.err, ex_er[i-1]); end
                vectors++; if (ifa.rdata !== ex_rd[i-1]) begin miscompares++; $display("FAIL oor_rdata[%0d] got %h want %h", i-1, ifa.rdata, ex_rd[i-1]); end
            end
        end
    endtask

    // Instance b (latency 3, 2 outstanding), request held high. Without a
    // retire bypass the hand-derived grant pattern is 1,1,0,0 repeating.
    task automatic test_outstanding();
        bit          ex_gnt [18] = '{1,1,0,0, 1,1,0,0, 1,1,0,0, 1,1,0,0, 0,0};
        logic        op_we [8];
        logic [31:0] op_ad [8];
        logic [31:0] op_wd [8];
        logic [31:0] q_data [$];
        int          q_due [$];
        int          nxt = 0;
        for (int k = 0; k < 4; k++) begin
            op_we[k] = 1; op_ad[k] = 32'h0010_0100 + 32'(4*k); op_wd[k] = 32'hC0DE_0000 + 32'(k);
            op_we[k+4] = 0; op_ad[k+4] = 32'h0010_0100 + 32'(4*k); op_wd[k+4] = 32'h0;
        end
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (nxt < 8) begin
                ifb.req = 1; ifb.we = op_we[nxt]; ifb.be = 4'hF;
                ifb.addr = op_ad[nxt]; ifb.wdata = op_wd[nxt];
            end else begin
                ifb.req = 0;
            end
            #1;
            vectors++; if (ifb.gnt !== ex_gnt[c]) begin miscompares++; $display("FAIL outst_gnt[c%0d] got %b want %b", c, ifb.gnt, ex_gnt[c]); end
            if (q_due.size() > 0 && q_due[0] == c) begin
                vectors++; if (ifb.rvalid !== 1'b1 || ifb.err !== 1'b0 || ifb.rdata !== q_data[0]) begin
                    miscompares++; $display("FAIL outst_resp[c%0d] got v=%b e=%b d=%h want v=1 e=0 d=%h", c, ifb.rvalid, ifb.err, ifb.rdata, q_data[0]);
                end
                void'(q_due.pop_front()); void'(q_data.pop_front());
            end else begin
                vectors++; if (ifb.rvalid !== 1'b0) begin miscompares++; $display("FAIL outst_rvalid[c%0d] got %b want 0", c, ifb.rvalid); end
            end
            if (ex_gnt[c] && nxt < 8) begin
                q_due.push_back(c + 3);
                q_data.push_back(op_we[nxt] ? 32'h0 : 32'hC0DE_0000 + 32'(nxt - 4));
                nxt++;
            end
        end
        vectors++; if (q_due.size() != 0) begin miscompares++; $display("FAIL outst_drain got %0d pending want 0", q_due.size()); end
    endtask

    // Instance c: reads outside the RAM, so every response is err=1 with rdata=0.
    task automatic test_stall();
        bit req_pat [13] = '{1,1,1,1, 1,1,1,1, 0,1,1,1, 1};
        bit ex_gnt  [13] = '{1,1,0,1, 1,0,1,1, 0,0,1,1, 0};
        bit ex_rv;
        for (int c = 0; c <= 13; c++) begin
            @(negedge clk);
            ifc.we = 0; ifc.be = 4'hF; ifc.addr = 32'h0; ifc.wdata = '0;
            ifc.req = (c < 13) ? req_pat[c] : 1'b0;
            #1;
            if (c < 13) begin
                vectors++; if (ifc.gnt !== ex_gnt[c]) begin miscompares++; $display("FAIL stall_gnt[c%0d] got %b want %b", c, ifc.gnt, ex_gnt[c]); end
            end
            ex_rv = (c > 0) ? ex_gnt[c-1] : 1'b0;
            vectors++; if (ifc.rvalid !== ex_rv || ifc.err !== ex_rv || ifc.rdata !== 32'h0) begin
                miscompares++; $display("FAIL stall_resp[c%0d] got v=%b e=%b d=%h want v=%b e=%b d=0", c, ifc.rvalid, ifc.err, ifc.rdata, ex_rv, ex_rv);
            end
        end
    endtask

    task automatic test_reset_inflight();
        @(negedge clk);
        ifb.req = 1; ifb.we = 0; ifb.be = 4'hF; ifb.addr = 32'h0010_0100;
        #1;
        vectors++; if (ifb.gnt !== 1'b1) begin miscompares++; $display("FAIL rst_rd0_gnt got %b want 1", ifb.gnt); end
        @(negedge clk);
        ifb.addr = 32'h0010_0104;
        #1;
        vectors++; if (ifb.gnt !== 1'b1) begin miscompares++; $display("FAIL rst_rd1_gnt got %b want 1", ifb.gnt); end
        @(negedge clk);
        ifb.req = 0;
        @(negedge clk);
        #1;
        vectors++; if (ifb.rvalid !== 1'b1) begin miscompares++; $display("FAIL rst_pre_rvalid got %b want 1", ifb.rvalid); end
        rst_ni = 1'b0;
        #1;
        vectors++; if (ifb.rvalid !== 1'b0 || ifb.rdata !== 32'h0) begin
            miscompares++; $display("FAIL rst_async_clear got v=%b d=%h want v=0 d=0", ifb.rvalid, ifb.rdata);
        end
        @(negedge clk);
        rst_ni = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            vectors++; if (ifb.rvalid !== 1'b0) begin miscompares++; $display("FAIL rst_ghost_rvalid[c%0d] got %b want 0", c, ifb.rvalid); end
        end
        @(negedge clk);
        ifb.req = 1; ifb.we = 0; ifb.addr = 32'h0010_0108;
        #1;
        vectors++; if (ifb.gnt !== 1'b1) begin miscompares++; $display("FAIL rst_post_gnt got %b want 1", ifb.gnt); end
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            ifb.req = 0;
            #1;
            if (j < 3) begin
                vectors++; if (ifb.rvalid !== 1'b0) begin miscompares++; $display("FAIL rst_post_early[%0d] got %b want 0", j, ifb.rvalid); end
            end else begin
                vectors++; if (ifb.rvalid !== 1'b1 || ifb.rdata !== 32'hC0DE_0002 || ifb.err !== 1'b0) begin
                    miscompares++; $display("FAIL rst_post_data got v=%b e=%b d=%h want v=1 e=0 d=c0de0002", ifb.rvalid, ifb.err, ifb.rdata);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_lanes();
        test_out_of_range();
        test_outstanding();
        test_stall();
        test_reset_inflight();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
